// File: rtl/kernel_seq_pkg.sv
// rtl/kernel_seq_pkg.sv - shared types and constants for the kernel channel sequencer
// Contents:
//   seq_state_t                 run-level FSM states
//   LP_DEFAULT_LENGTH_IN_BYTES  default per-channel transfer length
//   LP_MAX_CH                   largest supported channel count
//   LP_CURSOR_W                 cursor width; holds 0..LP_MAX_CH so "past the last channel" is representable
package kernel_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SCAN,
    ISSUE,
    WAIT,
    DONE
  } seq_state_t;

  localparam int LP_DEFAULT_LENGTH_IN_BYTES = 16384;
  localparam int LP_MAX_CH                  = 8;
  localparam int LP_CURSOR_W                = 4;

endpackage

// File: rtl/kernel_seq_pick.sv
// rtl/kernel_seq_pick.sv - masked priority encoder: lowest enabled index at or above cursor
// Ports:
//   enable  in   N            per-channel enable mask
//   cursor  in   LP_CURSOR_W  lowest index eligible for selection
//   found   out  1            some enabled index >= cursor exists
//   index   out  3            that lowest index (0 when found is low)
module kernel_seq_pick
  import kernel_seq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]             enable,
  input  logic [LP_CURSOR_W-1:0]   cursor,
  output logic                     found,
  output logic [2:0]               index
);

  // Walk from the top down so the last hit written is the lowest eligible index.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (enable[i] && (LP_CURSOR_W'(i) >= cursor)) begin
        found = 1'b1;
        index = 3'(i);
      end
    end
  end

endmodule

// File: rtl/kernel_channel_sequencer.sv
// rtl/kernel_channel_sequencer.sv - time-shares one vadd engine across enabled channel pairs per kernel run
// Optional feature macro: SEQ_PERF_CNT_EN (per-channel WAIT cycle counters on perf_cycles).
// Ports:
//   ap_clk, areset                 clock, synchronous active-high reset
//   ap_start / ap_idle / ap_done   host control: start level, idle level, completion pulse
//   ch_in_ptr / ch_out_ptr         per-channel read/write bases, channel i in slice i
//   ch_enable                      per-channel participation mask
//   xfer_size_in_bytes             per-channel transfer length
//   eng_start / eng_done           engine launch pulse / engine completion pulse
//   eng_rd_addr / eng_wr_addr      engine bases for the channel in flight
//   eng_xfer_size                  engine length
//   cur_ch                         channel in flight
//   err_size                       sticky: last run rejected for size
//   perf_cycles                    per-channel 32-bit WAIT cycle counts (0 when feature disabled)
module kernel_channel_sequencer
  import kernel_seq_pkg::*;
#(
  parameter int C_NUM_CH          = 4,
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_XFER_SIZE_WIDTH = 32,
  parameter int C_ALIGN_BYTES     = 64
) (
  input  logic                              ap_clk,
  input  logic                              areset,
  input  logic                              ap_start,
  output logic                              ap_idle,
  output logic                              ap_done,
  input  logic [C_NUM_CH*C_ADDR_WIDTH-1:0]  ch_in_ptr,
  input  logic [C_NUM_CH*C_ADDR_WIDTH-1:0]  ch_out_ptr,
  input  logic [C_NUM_CH-1:0]               ch_enable,
  input  logic [C_XFER_SIZE_WIDTH-1:0]      xfer_size_in_bytes,
  output logic                              eng_start,
  output logic [C_ADDR_WIDTH-1:0]           eng_rd_addr,
  output logic [C_ADDR_WIDTH-1:0]           eng_wr_addr,
  output logic [C_XFER_SIZE_WIDTH-1:0]      eng_xfer_size,
  input  logic                              eng_done,
  output logic [2:0]                        cur_ch,
  output logic                              err_size,
  output logic [C_NUM_CH*32-1:0]            perf_cycles
);

  if (C_NUM_CH < 1 || C_NUM_CH > LP_MAX_CH) begin : g_num_ch_check
    $error("kernel_channel_sequencer: C_NUM_CH must be within 1..LP_MAX_CH");
  end

  seq_state_t state, state_nxt;

  logic                              ap_start_r;
  logic                              start_pulse;
  logic [C_NUM_CH*C_ADDR_WIDTH-1:0]  lat_in_ptr;
  logic [C_NUM_CH*C_ADDR_WIDTH-1:0]  lat_out_ptr;
  logic [C_NUM_CH-1:0]               lat_enable;
  logic [C_XFER_SIZE_WIDTH-1:0]      lat_size;
  logic [LP_CURSOR_W-1:0]            cursor;
  logic                              pick_found;
  logic [2:0]                        pick_index;
  logic                              size_bad;

  // Edge detector register is deliberately outside reset; ap_start is low
  // whenever the host holds the kernel in reset.
  always_ff @(posedge ap_clk) begin
    ap_start_r <= ap_start;
  end

  assign start_pulse = ap_start & ~ap_start_r;

  assign size_bad = (lat_size == '0) ||
                    ((lat_size % C_XFER_SIZE_WIDTH'(C_ALIGN_BYTES)) != '0);

  kernel_seq_pick #(
    .N (C_NUM_CH)
  ) u_pick (
    .enable (lat_enable),
    .cursor (cursor),
    .found  (pick_found),
    .index  (pick_index)
  );

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ap_idle   = 1'b0;
    ap_done   = 1'b0;
    eng_start = 1'b0;
    unique case (state)
      IDLE: begin
        ap_idle = 1'b1;
        if (start_pulse) state_nxt = CHECK;
      end
      CHECK:   state_nxt = size_bad ? DONE : SCAN;
      SCAN:    state_nxt = pick_found ? ISSUE : DONE;
      ISSUE: begin
        eng_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (eng_done) state_nxt = SCAN;
      end
      DONE: begin
        ap_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Run-level datapath: argument snapshot, cursor, engine-facing registers.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      lat_in_ptr    <= '0;
      lat_out_ptr   <= '0;
      lat_enable    <= '0;
      lat_size      <= '0;
      cursor        <= '0;
      cur_ch        <= '0;
      err_size      <= 1'b0;
      eng_rd_addr   <= '0;
      eng_wr_addr   <= '0;
      eng_xfer_size <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_pulse) begin
            lat_in_ptr  <= ch_in_ptr;
            lat_out_ptr <= ch_out_ptr;
            lat_enable  <= ch_enable;
            lat_size    <= xfer_size_in_bytes;
          end
        end
        CHECK: begin
          err_size <= size_bad;
          cursor   <= '0;
        end
        SCAN: begin
          // Engine arguments change only here, so they stay stable from one ISSUE to the next.
          if (pick_found) begin
            cur_ch        <= pick_index;
            eng_rd_addr   <= lat_in_ptr[int'(pick_index)*C_ADDR_WIDTH +: C_ADDR_WIDTH];
            eng_wr_addr   <= lat_out_ptr[int'(pick_index)*C_ADDR_WIDTH +: C_ADDR_WIDTH];
            eng_xfer_size <= lat_size;
          end
        end
        WAIT: begin
          if (eng_done) cursor <= LP_CURSOR_W'(cur_ch) + LP_CURSOR_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_PERF_CNT_EN
  for (genvar i = 0; i < C_NUM_CH; i++) begin : g_perf
    logic [31:0] cnt;
    always_ff @(posedge ap_clk) begin
      if (areset) begin
        cnt <= '0;
      end else if (cur_ch == 3'(i)) begin
        if (state == ISSUE) begin
          cnt <= '0;
        end else if (state == WAIT && cnt != 32'hFFFF_FFFF) begin
          cnt <= cnt + 32'd1;
        end
      end
    end
    assign perf_cycles[i*32 +: 32] = cnt;
  end
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_kernel_channel_sequencer.sv
// tb/tb_kernel_channel_sequencer.sv - directed self-checking bench for kernel_channel_sequencer
module tb_kernel_channel_sequencer;
  import kernel_seq_pkg::*;

  logic         ap_clk = 1'b0;
  logic         areset;
  logic         ap_start;
  logic         ap_idle;
  logic         ap_done;
  logic [255:0] ch_in_ptr;
  logic [255:0] ch_out_ptr;
  logic [3:0]   ch_enable;
  logic [31:0]  xfer_size_in_bytes;
  logic         eng_start;
  logic [63:0]  eng_rd_addr;
  logic [63:0]  eng_wr_addr;
  logic [31:0]  eng_xfer_size;
  logic         eng_done;
  logic [2:0]   cur_ch;
  logic         err_size;
  logic [127:0] perf_cycles;

  int checks = 0;
  int failures = 0;

  always #5 ap_clk = ~ap_clk;

  kernel_channel_sequencer dut (
    .ap_clk             (ap_clk),
    .areset             (areset),
    .ap_start           (ap_start),
    .ap_idle            (ap_idle),
    .ap_done            (ap_done),
    .ch_in_ptr          (ch_in_ptr),
    .ch_out_ptr         (ch_out_ptr),
    .ch_enable          (ch_enable),
    .xfer_size_in_bytes (xfer_size_in_bytes),
    .eng_start          (eng_start),
    .eng_rd_addr        (eng_rd_addr),
    .eng_wr_addr        (eng_wr_addr),
    .eng_xfer_size      (eng_xfer_size),
    .eng_done           (eng_done),
    .cur_ch             (cur_ch),
    .err_size           (err_size),
    .perf_cycles        (perf_cycles)
  );

  function automatic logic [63:0] in_of(input int c);
    return 64'hA000_0000_0000_0000 + 64'(c) * 64'h1000;
  endfunction

  function automatic logic [63:0] out_of(input int c);
    return 64'hB000_0000_0000_0040 + 64'(c) * 64'h2000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ptrs();
    for (int c = 0; c < 4; c++) begin
      ch_in_ptr[c*64 +: 64]  = in_of(c);
      ch_out_ptr[c*64 +: 64] = out_of(c);
    end
  endtask

  // One kernel run from the current negedge. Sample k is the k-th negedge after
  // ap_start rises: k=1 CHECK, k=2 SCAN, k=3 first ISSUE. The engine answers
  // each eng_start with eng_done lat samples later.
  task automatic run(input string name, input logic [3:0] en, input logic [31:0] size,
                     input int lat, input bit exp_err, input bit perturb, input bit chk_addr);
    int st_k[8];
    logic [2:0]  st_ch[8];
    logic [63:0] st_rd[8];
    logic [63:0] st_wr[8];
    logic [31:0] st_sz[8];
    int exp_ch[8];
    int exp_n, n_start, n_done, done_k, idle_low, pend, exp_done;
    bit bad_addr;
    exp_n = 0;
    if (!exp_err) begin
      for (int c = 0; c < 4; c++) if (en[c]) begin exp_ch[exp_n] = c; exp_n++; end
    end
    exp_done = exp_err ? 2 : 3 + exp_n * (lat + 2);
    n_start = 0; n_done = 0; done_k = -1; idle_low = 0; pend = -1; bad_addr = 1'b0;
    set_ptrs();
    ch_enable = en;
    xfer_size_in_bytes = size;
    ap_start = 1'b1;
    for (int k = 1; k <= 1200; k++) begin
      @(negedge ap_clk);
      eng_done = 1'b0;
      if (k == 1) begin
        ap_start = 1'b0;
        if (perturb) begin
          ch_enable = ~en;
          xfer_size_in_bytes = 32'd0;
          ch_in_ptr = '1;
        end
      end
      if (perturb && k == 2) eng_done = 1'b1;
      if (perturb && k == 6) ap_start = 1'b1;
      if (perturb && k == 7) ap_start = 1'b0;
      if (eng_start) begin
        if (n_start < 8) begin
          st_k[n_start] = k; st_ch[n_start] = cur_ch; st_rd[n_start] = eng_rd_addr;
          st_wr[n_start] = eng_wr_addr; st_sz[n_start] = eng_xfer_size;
        end
        n_start++;
        pend = k + lat;
      end
      if (k == pend) eng_done = 1'b1;
      if (!ap_idle) idle_low++;
      if (ap_done) begin
        n_done++;
        if (done_k < 0) done_k = k;
      end
      if (chk_addr) begin
        for (int c = 0; c < 4; c++) if (!en[c] && eng_rd_addr === in_of(c)) bad_addr = 1'b1;
      end
      if (done_k >= 0 && k >= done_k + 3) break;
    end
    eng_done = 1'b0;
    chk({name, "_done_seen"}, done_k >= 0, 1'b1);
    chk({name, "_nstart"}, 64'(n_start), 64'(exp_n));
    for (int j = 0; j < exp_n && j < n_start && j < 8; j++) begin
      chk($sformatf("%s_ch%0d", name, j), 64'(st_ch[j]), 64'(exp_ch[j]));
      chk($sformatf("%s_rd%0d", name, j), st_rd[j], in_of(exp_ch[j]));
      chk($sformatf("%s_wr%0d", name, j), st_wr[j], out_of(exp_ch[j]));
      chk($sformatf("%s_sz%0d", name, j), 64'(st_sz[j]), 64'(size));
      chk($sformatf("%s_k%0d", name, j), 64'(st_k[j]), 64'(3 + j * (lat + 2)));
    end
    chk({name, "_done_k"}, 64'(done_k), 64'(exp_done));
    chk({name, "_ndone"}, 64'(n_done), 64'd1);
    chk({name, "_idle_low"}, 64'(idle_low), 64'(exp_done));
    chk({name, "_err"}, 64'(err_size), 64'(exp_err));
    if (chk_addr) chk({name, "_no_disabled_addr"}, 64'(bad_addr), 64'd0);
  endtask

  initial begin
    int seen2, pend, extra;
    areset = 1'b1; ap_start = 1'b0; eng_done = 1'b0;
    ch_in_ptr = '0; ch_out_ptr = '0; ch_enable = '0; xfer_size_in_bytes = '0;
    repeat (3) @(negedge ap_clk);
    areset = 1'b0;
    @(negedge ap_clk);
    chk("rst_idle", 64'(ap_idle), 64'd1);
    chk("rst_done", 64'(ap_done), 64'd0);
    chk("rst_eng_start", 64'(eng_start), 64'd0);
    chk("rst_rd", eng_rd_addr, 64'd0);
    chk("rst_wr", eng_wr_addr, 64'd0);
    chk("rst_sz", 64'(eng_xfer_size), 64'd0);
    chk("rst_cur_ch", 64'(cur_ch), 64'd0);
    chk("rst_err", 64'(err_size), 64'd0);
    chk("rst_perf", 64'(perf_cycles != '0), 64'd0);

    run("all4", 4'b1111, 32'(LP_DEFAULT_LENGTH_IN_BYTES), 3, 1'b0, 1'b0, 1'b0);
    run("odd", 4'b1010, 32'd16384, 2, 1'b0, 1'b0, 1'b1);
    run("size100", 4'b1111, 32'd100, 1, 1'b1, 1'b0, 1'b0);
    chk("err_sticky", 64'(err_size), 64'd1);
    run("size64", 4'b1001, 32'd64, 1, 1'b0, 1'b0, 1'b0);
    run("none", 4'b0000, 32'd16384, 1, 1'b0, 1'b0, 1'b0);
    run("perturb", 4'b1111, 32'd128, 4, 1'b0, 1'b1, 1'b0);
    run("size0", 4'b0110, 32'd0, 1, 1'b1, 1'b0, 1'b0);
    run("size16320", 4'b0100, 32'd16320, 2, 1'b0, 1'b0, 1'b0);

`ifdef SEQ_PERF_CNT_EN
    run("perf", 4'b0100, 32'd64, 500, 1'b0, 1'b0, 1'b0);
    chk("perf_ch2", 64'(perf_cycles[95:64]), 64'd500);
`else
    chk("perf_tied_zero", 64'(perf_cycles != '0), 64'd0);
`endif

    // Reset while channel 2 is in WAIT; its eng_done never arrives.
    set_ptrs();
    ch_enable = 4'b1111; xfer_size_in_bytes = 32'd4096; ap_start = 1'b1;
    seen2 = -1; pend = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge ap_clk);
      eng_done = 1'b0;
      if (k == 1) ap_start = 1'b0;
      if (eng_start) begin
        if (cur_ch == 3'd2) seen2 = k;
        else pend = k + 2;
      end
      if (k == pend) eng_done = 1'b1;
      if (seen2 > 0 && k == seen2 + 2) break;
    end
    eng_done = 1'b0;
    chk("mid_reached_ch2", 64'(seen2 > 0), 64'd1);
    chk("mid_busy", 64'(ap_idle), 64'd0);
    areset = 1'b1;
    @(negedge ap_clk);
    chk("mid_rst_idle", 64'(ap_idle), 64'd1);
    chk("mid_rst_done", 64'(ap_done), 64'd0);
    chk("mid_rst_eng_start", 64'(eng_start), 64'd0);
    chk("mid_rst_rd", eng_rd_addr, 64'd0);
    chk("mid_rst_wr", eng_wr_addr, 64'd0);
    chk("mid_rst_sz", 64'(eng_xfer_size), 64'd0);
    chk("mid_rst_cur_ch", 64'(cur_ch), 64'd0);
    chk("mid_rst_err", 64'(err_size), 64'd0);
    chk("mid_rst_perf", 64'(perf_cycles != '0), 64'd0);
    areset = 1'b0;
    extra = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge ap_clk);
      if (ap_done || eng_start || !ap_idle) extra++;
    end
    chk("mid_rst_quiet", 64'(extra), 64'd0);

    run("recover", 4'b0100, 32'd192, 1, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
